mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/ypu_pkg.sv | 38 +++
 rtl/mem_byte_seq.sv | 55 +++++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ypu_pkg.sv
// Shared encodings for the memory arbiter: FSM states, load/store size codes,
// grant tracking and the default I/O base address.
package ypu_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  localparam logic [ADDR_W-1:0] IO_BASE_DEF = 32'h0003_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    LS_RD = 2'd2,
    LS_WR = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } ls_size_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_LS = 1'b1
  } grant_t;

  // Byte count of a load/store; the unused code 3 is treated as a word.
  function automatic logic [CNT_W-1:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: holds the transaction base address and write data, counts
// bytes, and assembles read bytes little-endian.
module mem_byte_seq
  import ypu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic              cap,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [7:0]        din,
  output logic [CNT_W-1:0]  cnt,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wbyte,
  output logic [DATA_W-1:0] asm_data
);

  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] asm_q;
  logic [1:0]        lane;

  // Byte arriving on din belongs to the address issued one count earlier.
  assign lane = 2'(cnt - 3'd1);

  // Latch the transaction at grant, then advance and capture per byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base  <= '0;
      wdata <= '0;
      asm_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      base  <= addr_in;
      wdata <= wdata_in;
      asm_q <= '0;
      cnt   <= '0;
    end else begin
      if (cap) asm_q[{lane, 3'b000} +: 8] <= din;
      if (adv) cnt <= cnt + 3'd1;
    end
  end

  // Assembled word including the byte currently on din (used for the last byte).
  always_comb begin
    asm_data = asm_q;
    if (cnt != 3'd0) asm_data[{lane, 3'b000} +: 8] = din;
  end

  assign addr  = base + 32'(cnt);
  assign wbyte = wdata[{cnt[1:0], 3'b000} +: 8];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store onto a
// byte-wide RAM port. Optional statistics counters under MEM_ARB_STAT_EN.
module mem_arbiter
  import ypu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
`ifdef MEM_ARB_STAT_EN
  ,
  output logic [31:0]       stat_if_cnt,
  output logic [31:0]       stat_ls_cnt,
  output logic [31:0]       stat_stall_cnt
`endif
);

  arb_state_t        state;
  grant_t            last_grant;
  logic [CNT_W-1:0]  len;
  logic              is_io;

  logic              rd_busy;
  logic              can_grant;
  logic              grant_if;
  logic              grant_ls;
  logic              stall;
  logic              seq_load;
  logic              seq_adv;
  logic              seq_cap;
  logic [ADDR_W-1:0] seq_addr_in;
  logic [CNT_W-1:0]  seq_cnt;
  logic [ADDR_W-1:0] seq_addr;
  logic [7:0]        seq_wbyte;
  logic [DATA_W-1:0] seq_data;

  // Grant decision, stall detection and sequencer control.
  always_comb begin
    rd_busy     = (state == IF_RD) || (state == LS_RD);
    can_grant   = rdy && (state == IDLE) && !if_done && !ls_done;
    grant_if    = can_grant && if_req && (!ls_req || (last_grant == GRANT_LS));
    grant_ls    = can_grant && ls_req && !grant_if;
    stall       = (state == LS_WR) && is_io && io_buffer_full;
    seq_load    = grant_if || grant_ls;
    seq_addr_in = grant_if ? if_addr : ls_addr;
    seq_adv     = rdy && ((rd_busy && !clr && (seq_cnt != len)) ||
                          ((state == LS_WR) && !stall));
    seq_cap     = seq_adv && rd_busy && (seq_cnt != 3'd0);
  end

  // RAM port: write strobe is gated by rdy and the UART stall in the same cycle.
  assign mem_wr   = (state == LS_WR) && rdy && !stall;
  assign mem_a    = (state == IDLE) ? '0 : seq_addr;
  assign mem_dout = (state == LS_WR) ? seq_wbyte : 8'h00;

  mem_byte_seq u_seq (
    .clk      (clk),
    .rst      (rst),
    .load     (seq_load),
    .adv      (seq_adv),
    .cap      (seq_cap),
    .addr_in  (seq_addr_in),
    .wdata_in (ls_wdata),
    .din      (mem_din),
    .cnt      (seq_cnt),
    .addr     (seq_addr),
    .wbyte    (seq_wbyte),
    .asm_data (seq_data)
  );

  // Arbitration FSM with registered done pulses and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_LS;
      len        <= '0;
      is_io      <= 1'b0;
      if_done    <= 1'b0;
      ls_done    <= 1'b0;
      if_data    <= '0;
      ls_rdata   <= '0;
    end else if (rdy) begin
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            state      <= IF_RD;
            last_grant <= GRANT_IF;
            len        <= 3'd4;
            is_io      <= 1'b0;
          end else if (grant_ls) begin
            state      <= ls_we ? LS_WR : LS_RD;
            last_grant <= GRANT_LS;
            len        <= size_bytes(ls_size);
            is_io      <= (ls_addr >= IO_BASE);
          end
        end
        IF_RD: begin
          if (clr) begin
            state <= IDLE;
          end else if (seq_cnt == len) begin
            state   <= IDLE;
            if_done <= 1'b1;
            if_data <= seq_data;
          end
        end
        LS_RD: begin
          if (clr) begin
            state <= IDLE;
          end else if (seq_cnt == len) begin
            state    <= IDLE;
            ls_done  <= 1'b1;
            ls_rdata <= seq_data;
          end
        end
        LS_WR: begin
          if (!stall && (seq_cnt == 3'(len - 3'd1))) begin
            state   <= IDLE;
            ls_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STAT_EN
  // Completed-transaction and I/O stall cycle counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_if_cnt    <= '0;
      stat_ls_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else if (rdy) begin
      if ((state == IF_RD) && !clr && (seq_cnt == len))
        stat_if_cnt <= stat_if_cnt + 32'd1;
      if (((state == LS_RD) && !clr && (seq_cnt == len)) ||
          ((state == LS_WR) && !stall && (seq_cnt == 3'(len - 3'd1))))
        stat_ls_cnt <= stat_ls_cnt + 32'd1;
      if (stall)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide synchronous RAM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clr;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
`ifdef MEM_ARB_STAT_EN
  logic [31:0] stat_if_cnt;
  logic [31:0] stat_ls_cnt;
  logic [31:0] stat_stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] ram [logic [31:0]];

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clr            (clr),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .ls_req         (ls_req),
    .ls_we          (ls_we),
    .ls_size        (ls_size),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_done        (ls_done),
    .ls_rdata       (ls_rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
`ifdef MEM_ARB_STAT_EN
    ,
    .stat_if_cnt    (stat_if_cnt),
    .stat_ls_cnt    (stat_ls_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM: one-cycle read latency, frozen together with rdy.
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a] = mem_dout;
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  function automatic logic [31:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? 32'(ram[a]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = '0; ls_wdata = '0;
    io_buffer_full = 1'b0; mem_din = 8'h00;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h00; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h2000] = 8'h11; ram[32'h2001] = 8'h22; ram[32'h2002] = 8'h33; ram[32'h2003] = 8'h44;

    // Reset state
    cyc(2);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_if_done", 32'(if_done), 32'h0);
    chk("rst_ls_done", 32'(ls_done), 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    rst = 1'b0;
    step();
    chk("idle_mem_a", mem_a, 32'h0);

    // Simultaneous requests, last_grant=LS: IF first, then LS, then IF again
    if_req = 1'b1; if_addr = 32'h1000;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h2000;
    step();
    chk("arb_if_first_a", mem_a, 32'h1000);
    chk("arb_if_first_wr", 32'(mem_wr), 32'h0);
    step();
    chk("if_byte1_a", mem_a, 32'h1001);
    cyc(3);
    chk("if_done_early", 32'(if_done), 32'h0);
    step();
    chk("if_done_c5", 32'(if_done), 32'h1);
    chk("if_data", if_data, 32'h0000_0013);
    chk("ls_done_c5", 32'(ls_done), 32'h0);
    step();
    chk("gap_idle_a", mem_a, 32'h0);
    chk("gap_if_done", 32'(if_done), 32'h0);
    step();
    chk("arb_ls_second_a", mem_a, 32'h2000);
    cyc(4);
    chk("ls_done_early", 32'(ls_done), 32'h0);
    step();
    chk("ls_done_load", 32'(ls_done), 32'h1);
    chk("ls_rdata_4b", ls_rdata, 32'h4433_2211);
    ls_req = 1'b0;
    step();
    chk("gap2_idle_a", mem_a, 32'h0);
    step();
    chk("arb_if_third_a", mem_a, 32'h1000);

    // Flush during IF byte 2: no done, idle next cycle
    cyc(2);
    chk("if_abort_byte2_a", mem_a, 32'h1002);
    clr = 1'b1; if_req = 1'b0;
    step();
    clr = 1'b0;
    chk("if_abort_idle_a", mem_a, 32'h0);
    chk("if_abort_done", 32'(if_done), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("if_abort_no_done", 32'(if_done), 32'h0);
    end

    // Store 2B 0xBEEF @0x3000
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd1; ls_addr = 32'h3000; ls_wdata = 32'h0000_BEEF;
    step();
    chk("st2_c0_wr", 32'(mem_wr), 32'h1);
    chk("st2_c0_a", mem_a, 32'h3000);
    chk("st2_c0_dout", 32'(mem_dout), 32'hEF);
    step();
    chk("st2_c1_wr", 32'(mem_wr), 32'h1);
    chk("st2_c1_a", mem_a, 32'h3001);
    chk("st2_c1_dout", 32'(mem_dout), 32'hBE);
    chk("st2_c1_done", 32'(ls_done), 32'h0);
    step();
    chk("st2_c2_done", 32'(ls_done), 32'h1);
    chk("st2_c2_wr", 32'(mem_wr), 32'h0);
    ls_req = 1'b0;
    step();
    chk("st2_done_pulse", 32'(ls_done), 32'h0);

    // Store 4B with flush asserted throughout: store completes
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h3100; ls_wdata = 32'hA1B2_C3D4;
    step();
    chk("st4_c0_dout", 32'(mem_dout), 32'hD4);
    clr = 1'b1;
    step();
    chk("st4_clr_c1_wr", 32'(mem_wr), 32'h1);
    chk("st4_clr_c1_a", mem_a, 32'h3101);
    cyc(2);
    chk("st4_clr_c3_dout", 32'(mem_dout), 32'hA1);
    step();
    chk("st4_clr_done", 32'(ls_done), 32'h1);
    clr = 1'b0; ls_req = 1'b0;
    step();
    chk("st4_ram_lo", rd_ram(32'h3100), 32'hD4);
    chk("st4_ram_hi", rd_ram(32'h3103), 32'hA1);

    // Store just below IO_BASE ignores io_buffer_full
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h0002_FFFF; ls_wdata = 32'h77;
    step();
    chk("st_below_io_wr", 32'(mem_wr), 32'h1);
    step();
    chk("st_below_io_done", 32'(ls_done), 32'h1);
    ls_req = 1'b0;
    step();

    // I/O store at IO_BASE stalls three cycles
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h41;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("io_stall_wr", 32'(mem_wr), 32'h0);
      chk("io_stall_done", 32'(ls_done), 32'h0);
      step();
    end
    io_buffer_full = 1'b0;
    #1;
    chk("io_wr", 32'(mem_wr), 32'h1);
    chk("io_a", mem_a, 32'h0003_0000);
    chk("io_dout", 32'(mem_dout), 32'h41);
    step();
    chk("io_done", 32'(ls_done), 32'h1);
    chk("io_after_wr", 32'(mem_wr), 32'h0);
    ls_req = 1'b0;
`ifdef MEM_ARB_STAT_EN
    chk("stat_stall", stat_stall_cnt, 32'd3);
    chk("stat_if", stat_if_cnt, 32'd1);
    chk("stat_ls", stat_ls_cnt, 32'd5);
`endif
    step();

    // Load 2B zero-extended
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd1; ls_addr = 32'h2002;
    cyc(3);
    chk("ld2_early", 32'(ls_done), 32'h0);
    step();
    chk("ld2_done", 32'(ls_done), 32'h1);
    chk("ld2_rdata", ls_rdata, 32'h0000_4433);
    ls_req = 1'b0;
    step();

    // rdy low freezes a store and defers the done pulse
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd1; ls_addr = 32'h3200; ls_wdata = 32'h1234;
    step();
    chk("rdy_c0_wr", 32'(mem_wr), 32'h1);
    rdy = 1'b0;
    #1;
    chk("rdy_low_wr", 32'(mem_wr), 32'h0);
    step();
    chk("rdy_hold_wr", 32'(mem_wr), 32'h0);
    chk("rdy_hold_a", mem_a, 32'h3200);
    rdy = 1'b1;
    #1;
    chk("rdy_resume_dout", 32'(mem_dout), 32'h34);
    step();
    chk("rdy_c1_a", mem_a, 32'h3201);
    chk("rdy_c1_dout", 32'(mem_dout), 32'h12);
    step();
    chk("rdy_done", 32'(ls_done), 32'h1);
    rdy = 1'b0; ls_req = 1'b0;
    step();
    chk("rdy_done_held", 32'(ls_done), 32'h1);
    rdy = 1'b1;
    step();
    chk("rdy_done_clear", 32'(ls_done), 32'h0);
    chk("rdy_ram_lo", rd_ram(32'h3200), 32'h34);
    chk("rdy_ram_hi", rd_ram(32'h3201), 32'h12);

    // Reset in the middle of a load
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h2000;
    cyc(3);
    chk("rst_mid_a_before", mem_a, 32'h2002);
    rst = 1'b1;
    #1;
    chk("rst_mid_a", mem_a, 32'h0);
    chk("rst_mid_wr", 32'(mem_wr), 32'h0);
    chk("rst_mid_done", 32'(ls_done), 32'h0);
    chk("rst_mid_rdata", ls_rdata, 32'h0);
    ls_req = 1'b0;
    step();
    rst = 1'b0;
`ifdef MEM_ARB_STAT_EN
    chk("rst_stat_ls", stat_ls_cnt, 32'd0);
    chk("rst_stat_stall", stat_stall_cnt, 32'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst_mid_no_done", 32'(ls_done), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
